// File: rtl/mdu_sched_if.sv
// Port bundle for mdu_sched: EXE request/response handshake plus the divider's
// AXI-stream operand channels and result channel.
interface mdu_sched_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic        busy;
  logic        div_signed;
  logic [31:0] dividend_tdata;
  logic [31:0] divisor_tdata;
  logic        dividend_tvalid;
  logic        divisor_tvalid;
  logic        dividend_tready;
  logic        divisor_tready;
  logic        dout_tvalid;
  logic [63:0] dout_tdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush, resp_ready,
           dividend_tready, divisor_tready, dout_tvalid, dout_tdata,
    output req_ready, resp_valid, busy, div_signed, dividend_tdata, divisor_tdata,
           dividend_tvalid, divisor_tvalid, hi, lo
  );

  modport master (
    output req_valid, req_op, req_src1, req_src2, flush, resp_ready,
           dividend_tready, divisor_tready, dout_tvalid, dout_tdata,
    input  req_ready, resp_valid, busy, div_signed, dividend_tdata, divisor_tdata,
           dividend_tvalid, divisor_tvalid, hi, lo
  );
endinterface

// File: rtl/mdu_sched.sv
// HI/LO owner and mult/div sequencer for the execute stage, driving a shared divider IP.
// Optional MDU_DIV0_BYPASS_EN: zero-divisor div/divu completes locally without the divider.
module mdu_sched (
  input logic        clk,
  input logic        reset,
  mdu_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, DRAIN} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state_q, state_d;
  logic        sent_dvd_q, sent_dvd_d, sent_dvs_q, sent_dvs_d;
  logic        flushed_q, flushed_d;
  logic        resp_valid_q, resp_valid_d, busy_q, busy_d;
  logic        div_signed_q, div_signed_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] dividend_q, dividend_d, divisor_q, divisor_d;
  logic        dvd_vld, dvs_vld, dvd_now, dvs_now, accept;

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [63:0] sa, sb;
    sa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    sb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return sa * sb;
  endfunction

  assign bus.req_ready       = (state_q == IDLE) && !bus.flush;
  assign dvd_vld             = (state_q == SEND) && !sent_dvd_q;
  assign dvs_vld             = (state_q == SEND) && !sent_dvs_q;
  assign bus.dividend_tvalid = dvd_vld;
  assign bus.divisor_tvalid  = dvs_vld;
  assign accept              = bus.req_valid && bus.req_ready;
  // Channel counts as sent if it already was, or handshakes this cycle.
  assign dvd_now             = sent_dvd_q || (dvd_vld && bus.dividend_tready);
  assign dvs_now             = sent_dvs_q || (dvs_vld && bus.divisor_tready);

  always_comb begin
    state_d      = state_q;
    sent_dvd_d   = sent_dvd_q;
    sent_dvs_d   = sent_dvs_q;
    flushed_d    = flushed_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_signed_d = div_signed_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dividend_d   = bus.req_src1;
          divisor_d    = bus.req_src2;
          div_signed_d = (bus.req_op == OP_DIV);
          state_d      = DONE;
          case (bus.req_op)
            OP_MULT:  {hi_d, lo_d} = mul64(bus.req_src1, bus.req_src2, 1'b1);
            OP_MULTU: {hi_d, lo_d} = mul64(bus.req_src1, bus.req_src2, 1'b0);
            OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV0_BYPASS_EN
              if (bus.req_src2 == 32'd0) begin
                lo_d = 32'hFFFF_FFFF;
                hi_d = bus.req_src1;
              end else begin
                state_d = SEND;
              end
`else
              state_d = SEND;
`endif
            end
            OP_MTHI:  hi_d = bus.req_src1;
            OP_MTLO:  lo_d = bus.req_src1;
            default:  ;
          endcase
        end
      end
      SEND: begin
        sent_dvd_d = dvd_now;
        sent_dvs_d = dvs_now;
        flushed_d  = flushed_q || bus.flush;
        // A flushed half-pair must still be completed so the divider stays paired.
        if (dvd_now && dvs_now) begin
          state_d = flushed_d ? DRAIN : WAIT;
        end else if (bus.flush && !dvd_now && !dvs_now) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_d = bus.dout_tvalid ? IDLE : DRAIN;
        end else if (bus.dout_tvalid) begin
          lo_d    = bus.dout_tdata[63:32];
          hi_d    = bus.dout_tdata[31:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.resp_ready || bus.flush) state_d = IDLE;
      end
      DRAIN: begin
        if (bus.dout_tvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      sent_dvd_d = 1'b0;
      sent_dvs_d = 1'b0;
      flushed_d  = 1'b0;
    end
    resp_valid_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sent_dvd_q   <= 1'b0;
      sent_dvs_q   <= 1'b0;
      flushed_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      div_signed_q <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      dividend_q   <= 32'd0;
      divisor_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      sent_dvd_q   <= sent_dvd_d;
      sent_dvs_q   <= sent_dvs_d;
      flushed_q    <= flushed_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      div_signed_q <= div_signed_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
    end
  end

  assign bus.resp_valid     = resp_valid_q;
  assign bus.busy           = busy_q;
  assign bus.div_signed     = div_signed_q;
  assign bus.hi             = hi_q;
  assign bus.lo             = lo_q;
  assign bus.dividend_tdata = dividend_q;
  assign bus.divisor_tdata  = divisor_q;
endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide sequencer that owns the HI/LO register pair and schedules the MIPS mult/multu/div/divu/mthi/mtlo operations for the execute stage. It accepts one operation at a time from EXE, drives the AXI-stream operand channels of the shared divider IP (signed and unsigned modes through one port set), waits for the quotient/remainder, commits HI/LO and reports completion. It also handles pipeline flushes safely while a division is in flight, so the divider never pairs stale operands with a new request.

## Interface
- No parameters; widths are fixed at 32-bit operands and a 64-bit divider result.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  EXE offers an operation
- req_ready  out  1  `state==IDLE && !flush`
- req_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved
- req_src1  in  32  rs value (dividend, multiplicand, mt source)
- req_src2  in  32  rt value (divisor, multiplier)
- flush  in  1  cancel the current operation
- resp_valid  out  1  operation committed
- resp_ready  in  1  EXE advances
- busy  out  1  `state!=IDLE`
- div_signed  out  1  1 = signed divide; registered at acceptance
- dividend_tdata / divisor_tdata  out  32 each  latched operands
- dividend_tvalid / divisor_tvalid  out  1 each  operand channel valid
- dividend_tready / divisor_tready  in  1 each  divider accepts
- dout_tvalid  in  1  divider result valid, single-cycle pulse
- dout_tdata  in  64  [63:32] quotient, [31:0] remainder
- hi / lo  out  32 each  current HI/LO contents

## Operation
- **States:** IDLE, SEND, WAIT, DONE, DRAIN.
- **Acceptance:** on `req_valid && req_ready`, latch the operands, op and div_signed.
- **Single-cycle ops (IDLE):**
  - mult: {HI,LO} ← signed 64-bit product.
  - multu: {HI,LO} ← unsigned 64-bit product.
  - mthi: HI ← src1. mtlo: LO ← src1.
  - The write happens at the acceptance edge; next state is DONE.
- **Reserved opcodes:** accepted with no HI/LO change; next state is DONE.
- **div/divu:** IDLE → SEND. Each channel's tvalid is high while its per-channel `sent` flag is 0.
  - A flag sets on that channel's `tvalid && tready`.
  - When both flags are set, go to WAIT.
  - Flags clear on entry to IDLE.
- **WAIT:** on dout_tvalid, LO ← quotient, HI ← remainder, go to DONE.
- **DONE:** resp_valid=1. On resp_ready, go to IDLE. A new request is accepted no earlier than the next cycle.
- **Flush (flush=1):**
  - In IDLE: no acceptance.
  - In DONE: go to IDLE (HI/LO already committed, not rolled back).
  - In SEND with neither flag set: deassert both tvalids and go to IDLE.
  - In SEND with exactly one flag set: keep presenting the unsent channel until it is accepted, then go to DRAIN. This prevents a half-pair from corrupting the next division.
  - In WAIT: go to DRAIN.
  - If dout_tvalid arrives in the flush cycle, it is discarded.
- **DRAIN:** busy=1, req_ready=0. On dout_tvalid, discard the result (no HI/LO write) and go to IDLE. Further flushes are ignored.
- **HI/LO writes** occur only at the edges stated above. HI/LO never change in SEND, DRAIN or DONE.

## Timing
- **Reset values:**
  - state IDLE, both sent flags 0.
  - hi = lo = 0, resp_valid = 0, both tvalids 0, busy = 0, div_signed = 0.
  - dividend_tdata and divisor_tdata are 0.
- **Mult/mt latency:** accept at edge N; HI/LO visible and resp_valid high from cycle N+1.
- **Div latency:** 1 cycle to SEND + operand handshake (≥1 cycle) + divider latency L. resp_valid rises the cycle after dout_tvalid.
- resp_valid stays high until resp_ready; resp_ready is ignored when resp_valid=0.
- All outputs are driven from registers except req_ready and tvalids, which are decoded from state and flags only (no combinational path from tready).
- Reset mid-operation returns to IDLE immediately. Recovering the divider IP is the responsibility of the system reset.
- dout_tvalid outside WAIT/DRAIN is ignored.

## Configuration
- **MDU_DIV0_BYPASS_EN defined:**
  - div/divu with req_src2==0 never enters SEND.
  - At the acceptance edge, LO ← 32'hFFFF_FFFF and HI ← src1; next state is DONE.
  - Latency is the same as mult.
- **Undefined:** a zero divisor is sent to the divider like any other value, and the IP's result is committed.

## Test plan
- **multu:** src1=0xFFFF_FFFF, src2=0x2 → HI=0x1, LO=0xFFFF_FFFE, resp_valid on cycle N+1.
- **div with 3-cycle tready stall on divisor:** src1=-7, src2=2, divider returns {q=-3, r=-1} → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; divisor_tvalid held for 3 cycles; dividend sent exactly once.
- **Flush in SEND after only the dividend was accepted:** divisor still presented until tready, then DRAIN. The later dout_tvalid is discarded with HI/LO unchanged; the next divu 10/3 gives LO=3, HI=1.
- **Flush in WAIT, with a new req_valid held high:** req_ready stays 0 until dout_tvalid is consumed in DRAIN; the request is then accepted one cycle later.
- **Back-pressure:** resp_ready=0 for 4 cycles after mthi 0x1234 → resp_valid stays high, hi=0x1234, busy=1, no new acceptance.
- **Zero divisor:** divu 5/0 with MDU_DIV0_BYPASS_EN → no tvalid asserted, LO=0xFFFF_FFFF, HI=5 at N+1. Without the macro → operands are sent to the divider.
